// File: rtl/reset_request_source.sv
`default_nettype none
// ============================================================================
//  Module   : reset_request_source
//  Purpose  : Merges push-button, watchdog and software reset triggers into
//             one clean, fixed-width, clock-synchronous reset request pulse.
//             It also records the cause of the last accepted trigger. The
//             block lives in the always-on power-on domain.
//  Options  : RESET_REQUEST_WATCHDOG_EN - build the watchdog counter/trigger.
//             When this is undefined, wdt_enable/wdt_kick are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_request_source #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int WATCHDOG_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int HOLDOFF_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       button_in,
  input  logic       sw_req,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  output logic       reset_req,
  output logic [1:0] cause,
  output logic       busy
);

  // Debounce counter must be able to hold DEBOUNCE_CYCLES itself.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);

  // PULSE and HOLDOFF never overlap, so a single phase counter serves both.
  localparam int PH_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PULSE_LOAD = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LOAD  = PH_W'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_WDT    = 2'b10;
  localparam logic [1:0] CAUSE_SW     = 2'b11;

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic [PH_W-1:0] phase_cnt;
  logic [PH_W-1:0] next_cnt;
  logic [1:0]      next_cause;
  logic            req_d;
  logic            busy_d;

  logic            btn_meta;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            db_level_q;

  logic            btn_trig;
  logic            wdt_trig;
  logic            sw_trig;

  // ---------------------------------------------------------------------------
  // Button path
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer for the raw, asynchronous button.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= button_in;
      btn_sync <= btn_meta;
    end
  end

  // Debouncer: flip the level only after a full run of disagreeing clocks.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
    end else begin
      db_level_q <= db_level;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LIMIT) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // A press is only the rising edge; holding the button cannot retrigger.
  assign btn_trig = db_level & ~db_level_q;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef RESET_REQUEST_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Reload when disabled, kicked or busy; otherwise count down and park at 0.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      wd_cnt <= WD_LOAD;
    end else if (!wdt_enable || (state != ST_IDLE) || wdt_kick) begin
      wd_cnt <= WD_LOAD;
    end else if (wd_cnt != '0) begin
      wd_cnt <= wd_cnt - WD_W'(1);
    end
  end

  assign wdt_trig = (state == ST_IDLE) && (wd_cnt == '0);
`else
  logic unused_wdt_inputs;
  assign unused_wdt_inputs = wdt_enable | wdt_kick;
  assign wdt_trig          = 1'b0;
`endif

  // Software request is level-sampled and only honoured in IDLE.
  assign sw_trig = sw_req && (state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------

  // State, phase counter, cause and registered outputs.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      cause     <= CAUSE_POR;
      reset_req <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      phase_cnt <= next_cnt;
      cause     <= next_cause;
      reset_req <= req_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic: accept one trigger in IDLE, then time PULSE and HOLDOFF.
  always_comb begin
    next_state = state;
    next_cnt   = phase_cnt;
    next_cause = cause;
    case (state)
      ST_IDLE: begin
        if (btn_trig || wdt_trig || sw_trig) begin
          next_state = ST_PULSE;
          next_cnt   = PULSE_LOAD;
          if (btn_trig) begin
            next_cause = CAUSE_BUTTON;
          end else if (wdt_trig) begin
            next_cause = CAUSE_WDT;
          end else begin
            next_cause = CAUSE_SW;
          end
        end
      end
      ST_PULSE: begin
        if (phase_cnt == '0) begin
          next_state = ST_HOLDOFF;
          next_cnt   = HOLD_LOAD;
        end else begin
          next_cnt = phase_cnt - PH_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (phase_cnt == '0) begin
          next_state = ST_IDLE;
        end else begin
          next_cnt = phase_cnt - PH_W'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so the flops line up with the state.
  always_comb begin
    req_d  = (next_state == ST_PULSE);
    busy_d = (next_state == ST_PULSE) || (next_state == ST_HOLDOFF);
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_request_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_request_source
//  Purpose  : Self-checking bench for reset_request_source. Expected pulses
//             (rise cycle and cause) are queued when stimulus is driven and
//             popped by a monitor when reset_req rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_request_source;

  localparam int DB  = 8;
  localparam int WDT = 100;
  localparam int PC  = 4;
  localparam int HC  = 16;

  logic       clk;
  logic       reset_in;
  logic       button_in;
  logic       sw_req;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       reset_req;
  logic [1:0] cause;
  logic       busy;

  reset_request_source #(
    .DEBOUNCE_CYCLES(DB),
    .WATCHDOG_CYCLES(WDT),
    .PULSE_CYCLES   (PC),
    .HOLDOFF_CYCLES (HC)
  ) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .button_in (button_in),
    .sw_req    (sw_req),
    .wdt_enable(wdt_enable),
    .wdt_kick  (wdt_kick),
    .reset_req (reset_req),
    .cause     (cause),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Scoreboard of expected pulses.
  typedef struct {
    int         rise_cyc;
    logic [1:0] cause;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int rc, input logic [1:0] ca);
    exp_t e;
    e.rise_cyc = rc;
    e.cause    = ca;
    exp_q.push_back(e);
  endtask

  // Monitor: pop an expectation on each rise and check pulse/busy widths.
  int   pw = 0;
  int   bw = 0;
  logic prev_req  = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_in) begin
      pw        = 0;
      bw        = 0;
      prev_req  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (reset_req && !prev_req) begin
        pw = 1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: rise at cycle %0d cause %0d, want no pulse", cyc, cause);
        end else begin
          e = exp_q.pop_front();
          check("pulse_rise_cycle", cyc, e.rise_cyc);
          check("pulse_cause", {30'd0, cause}, {30'd0, e.cause});
          check("busy_with_rise", {31'd0, busy}, 32'd1);
        end
      end else if (reset_req) begin
        pw++;
      end else if (prev_req) begin
        check("pulse_width", pw, PC);
      end

      if (busy && !prev_busy) begin
        bw = 1;
      end else if (busy) begin
        bw++;
      end else if (prev_busy) begin
        check("busy_width", bw, PC + HC);
      end

      prev_req  = reset_req;
      prev_busy = busy;
    end
  end

  // Table of single-trigger vectors.
  typedef enum int {K_SW, K_BTN, K_WDT} kind_e;
  typedef struct {
    kind_e      kind;
    bit         exp_pulse;
    int         latency;
    logic [1:0] exp_cause;
  } vec_t;
  vec_t vecs[4];

  int c0;

  initial begin
    reset_in   = 1'b1;
    button_in  = 1'b0;
    sw_req     = 1'b0;
    wdt_enable = 1'b0;
    wdt_kick   = 1'b0;

    vecs[0] = '{K_SW,  1'b1, 1,      2'b11};
    vecs[1] = '{K_BTN, 1'b1, DB + 4, 2'b01};
    vecs[2] = '{K_SW,  1'b1, 1,      2'b11};
`ifdef RESET_REQUEST_WATCHDOG_EN
    vecs[3] = '{K_WDT, 1'b1, WDT + 1, 2'b10};
`else
    vecs[3] = '{K_WDT, 1'b0, WDT + 1, 2'b11};
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_req_in_reset", {31'd0, reset_req}, 32'd0);
    check("busy_in_reset", {31'd0, busy}, 32'd0);
    check("cause_in_reset", {30'd0, cause}, 32'd0);
    reset_in = 1'b0;
    repeat (4) @(negedge clk);
    check("cause_after_release", {30'd0, cause}, 32'd0);

    // Table-driven single triggers.
    for (int i = 0; i < 4; i++) begin
      case (vecs[i].kind)
        K_SW: begin
          sw_req = 1'b1;
          c0 = cyc;
          if (vecs[i].exp_pulse) push_exp(c0 + vecs[i].latency, vecs[i].exp_cause);
          @(negedge clk);
          sw_req = 1'b0;
          repeat (PC + HC + 10) @(negedge clk);
        end
        K_BTN: begin
          button_in = 1'b1;
          c0 = cyc;
          if (vecs[i].exp_pulse) push_exp(c0 + vecs[i].latency, vecs[i].exp_cause);
          repeat (vecs[i].latency + PC + HC + 10) @(negedge clk);
          button_in = 1'b0;
          repeat (DB + 10) @(negedge clk);
        end
        default: begin
          wdt_enable = 1'b1;
          for (int k = 0; k < 4; k++) begin
            wdt_kick = 1'b1;
            @(negedge clk);
            wdt_kick = 1'b0;
            repeat (49) @(negedge clk);
          end
          wdt_kick = 1'b1;
          c0 = cyc;
          if (vecs[i].exp_pulse) push_exp(c0 + vecs[i].latency, vecs[i].exp_cause);
          @(negedge clk);
          wdt_kick = 1'b0;
          repeat (WDT + 40) @(negedge clk);
          wdt_enable = 1'b0;
          repeat (5) @(negedge clk);
        end
      endcase
      check($sformatf("cause_after_vec%0d", i), {30'd0, cause}, {30'd0, vecs[i].exp_cause});
    end

    // Bouncing button never settles; then steady high, held through HOLDOFF.
    for (int k = 0; k < 16; k++) begin
      button_in = ~button_in;
      repeat (3) @(negedge clk);
    end
    button_in = 1'b0;
    repeat (5) @(negedge clk);
    check("cause_after_bounce", {30'd0, cause}, {30'd0, vecs[3].exp_cause});
    button_in = 1'b1;
    push_exp(cyc + DB + 4, 2'b01);
    repeat (60) @(negedge clk);
    button_in = 1'b0;
    repeat (DB + 10) @(negedge clk);
    check("cause_after_debounce", {30'd0, cause}, 32'd1);

    // Set up a software cause so the priority result is distinguishable.
    sw_req = 1'b1;
    push_exp(cyc + 1, 2'b11);
    @(negedge clk);
    sw_req = 1'b0;
    repeat (PC + HC + 5) @(negedge clk);

    // Button, watchdog expiry and software request in the same clock.
    wdt_enable = 1'b1;
    wdt_kick   = 1'b1;
    c0 = cyc;
    @(negedge clk);
    wdt_kick = 1'b0;
    repeat (88) @(negedge clk);
    button_in = 1'b1;
    repeat (11) @(negedge clk);
    sw_req = 1'b1;
    push_exp(c0 + WDT + 1, 2'b01);
    @(negedge clk);
    sw_req = 1'b0;
    repeat (8) @(negedge clk);
    // Software request during HOLDOFF must be dropped.
    sw_req = 1'b1;
    @(negedge clk);
    sw_req     = 1'b0;
    wdt_enable = 1'b0;
    repeat (40) @(negedge clk);
    button_in = 1'b0;
    repeat (DB + 10) @(negedge clk);
    check("cause_after_priority", {30'd0, cause}, 32'd1);

    // Reset asserted during the second PULSE clock.
    sw_req = 1'b1;
    c0 = cyc;
    push_exp(c0 + 1, 2'b11);
    @(negedge clk);
    sw_req = 1'b0;
    @(negedge clk);
    #2 reset_in = 1'b1;
    #1;
    check("reset_req_mid_reset", {31'd0, reset_req}, 32'd0);
    check("busy_mid_reset", {31'd0, busy}, 32'd0);
    check("cause_mid_reset", {30'd0, cause}, 32'd0);
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    sw_req = 1'b1;
    push_exp(cyc + 1, 2'b11);
    @(negedge clk);
    sw_req = 1'b0;
    repeat (PC + HC + 10) @(negedge clk);
    check("cause_after_recovery", {30'd0, cause}, 32'd3);

    check("pending_expected_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
